// File: rtl/conv_core_v2_if.sv
// conv_core_v2_if: AXI-Stream result channel between conv_core_v2 and its consumer.
// OUTW is derived here from the core's parameters so both ends always agree on width.
interface conv_core_v2_if #(
  parameter int INW  = 24,
  parameter int MAXK = 4,
  parameter int CH   = 2
);
  localparam int OUTW = $clog2(64'(CH) * 64'(MAXK) * 64'(MAXK) * (64'd1 << (2 * INW - 2))
                               + (64'd1 << (INW - 1))) + 1;

  logic [OUTW-1:0] OUT_TDATA;
  logic            OUT_TVALID;
  logic            OUT_TREADY;

  modport master (output OUT_TDATA, output OUT_TVALID, input OUT_TREADY);
  modport slave  (input OUT_TDATA, input OUT_TVALID, output OUT_TREADY);
endinterface

// File: rtl/conv_core_v2.sv
// conv_core_v2: fully pipelined multi-channel 2D convolution core, one MAC per cycle.
// Define CONV_RELU_EN to clamp every emitted result to max(result, 0).
module conv_core_v2 #(
  parameter int  INW    = 24,
  parameter int  R      = 9,
  parameter int  C      = 8,
  parameter int  MAXK   = 4,
  parameter int  CH     = 2,
  localparam int OUTW   = $clog2(64'(CH) * 64'(MAXK) * 64'(MAXK) * (64'd1 << (2 * INW - 2))
                                 + (64'd1 << (INW - 1))) + 1,
  localparam int K_BITS = $clog2(MAXK + 1),
  localparam int XAW    = $clog2(CH * R * C),
  localparam int WAW    = $clog2(CH * MAXK * MAXK)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [K_BITS-1:0]     K,
  input  logic                  stride2,
  input  logic signed [INW-1:0] B,
  output logic [XAW-1:0]        X_read_addr,
  input  logic signed [INW-1:0] X_data,
  output logic [WAW-1:0]        W_read_addr,
  input  logic signed [INW-1:0] W_data,
  output logic                  done,
  output logic                  busy,
  conv_core_v2_if.master        axis
);

  localparam int RW  = $clog2(R + 1);
  localparam int CW  = $clog2(C + 1);
  localparam int CHW = $clog2(CH + 1);
  localparam int PW  = 2 * INW;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [K_BITS-1:0]     k_q;
  logic                  s2_q;
  logic signed [INW-1:0] b_q;

  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [K_BITS-1:0] i_q, i_d;
  logic [K_BITS-1:0] j_q, j_d;

  logic s1_valid_q, s1_first_q, s1_last_q;
  logic s2_valid_q, s2_first_q, s2_last_q;

  logic signed [PW-1:0]   prod_q, prod_d;
  logic signed [OUTW-1:0] acc_q, acc_d, res_d;
  logic signed [INW-1:0]  x_hold_q, w_hold_q, x_s1, w_s1;
  logic                   fresh_q;

  logic [OUTW-1:0] out_data_q;
  logic            out_valid_q;

  logic        en, s0_valid;
  logic        at_j_end, at_i_end, at_ch_end, at_c_end, at_r_end;
  logic        tap_first, tap_last, win_last;
  int unsigned kk, rout, cout, row, col;

  assign en       = !(out_valid_q && !axis.OUT_TREADY);
  assign s0_valid = (state_q == StRun);
  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);

  assign axis.OUT_TDATA  = out_data_q;
  assign axis.OUT_TVALID = out_valid_q;

  // Geometry, wrap detection and tap addresses, all derived from the live counters.
  always_comb begin
    kk   = 32'(k_q);
    rout = ((32'(R) - kk) >> s2_q) + 32'd1;
    cout = ((32'(C) - kk) >> s2_q) + 32'd1;

    at_j_end  = (32'(j_q) == kk - 32'd1);
    at_i_end  = (32'(i_q) == kk - 32'd1);
    at_ch_end = (32'(ch_q) == 32'(CH - 1));
    at_c_end  = (32'(c_q) == cout - 32'd1);
    at_r_end  = (32'(r_q) == rout - 32'd1);

    tap_first = (i_q == '0) && (j_q == '0) && (ch_q == '0);
    tap_last  = at_j_end && at_i_end && at_ch_end;
    win_last  = tap_last && at_c_end && at_r_end;

    row = (s2_q ? (32'(r_q) << 1) : 32'(r_q)) + 32'(i_q);
    col = (s2_q ? (32'(c_q) << 1) : 32'(c_q)) + 32'(j_q);

    X_read_addr = XAW'(32'(ch_q) * 32'(R * C) + row * 32'(C) + col);
    W_read_addr = WAW'(32'(ch_q) * kk * kk + 32'(i_q) * kk + 32'(j_q));
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    ch_d    = ch_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (en) begin
          j_d = at_j_end ? '0 : j_q + 1'b1;
          if (at_j_end) begin
            i_d = at_i_end ? '0 : i_q + 1'b1;
            if (at_i_end) begin
              ch_d = at_ch_end ? '0 : ch_q + 1'b1;
              if (at_ch_end) begin
                c_d = at_c_end ? '0 : c_q + 1'b1;
                if (at_c_end) begin
                  r_d = at_r_end ? '0 : r_q + 1'b1;
                  if (at_r_end) state_d = StDrain;
                end
              end
            end
          end
        end
      end
      StDrain: begin
        if (!s1_valid_q && !s2_valid_q && (!out_valid_q || axis.OUT_TREADY)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      s2_q    <= 1'b0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      ch_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ch_q    <= ch_d;
      i_q     <= i_d;
      j_q     <= j_d;
      if (state_q == StIdle && start) begin
        k_q  <= K;
        s2_q <= stride2;
        b_q  <= B;
      end
    end
  end

  // Memory data reflects the address of the previous cycle. Once a stall starts the address
  // stays on the next tap, so the S1 word is captured and replayed until the pipe moves again.
  assign x_s1 = fresh_q ? X_data : x_hold_q;
  assign w_s1 = fresh_q ? W_data : w_hold_q;

  always_comb begin
    prod_d = PW'(x_s1) * PW'(w_s1);
    acc_d  = s2_first_q ? (OUTW'(b_q) + OUTW'(prod_q)) : (acc_q + OUTW'(prod_q));
`ifdef CONV_RELU_EN
    res_d  = acc_d[OUTW-1] ? '0 : acc_d;
`else
    res_d  = acc_d;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fresh_q  <= 1'b1;
      x_hold_q <= '0;
      w_hold_q <= '0;
    end else begin
      fresh_q <= en;
      if (fresh_q) begin
        x_hold_q <= X_data;
        w_hold_q <= W_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else if (en) begin
      s1_valid_q <= s0_valid;
      s1_first_q <= s0_valid && tap_first;
      s1_last_q  <= s0_valid && tap_last;
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q) prod_q <= prod_d;
      if (s2_valid_q) acc_q <= acc_d;
    end
  end

  // A new result may load in the same cycle the previous one transfers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && axis.OUT_TREADY) out_valid_q <= 1'b0;
      if (en && s2_valid_q && s2_last_q) begin
        out_data_q  <= res_d;
        out_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_core_v2.sv
// tb_conv_core_v2: randomized scoreboard bench for conv_core_v2 with a plain-arithmetic
// convolution model; expected results are queued at start and checked by a monitor.
`timescale 1ns/1ps
module tb_conv_core_v2;

  localparam int INW    = 24;
  localparam int R      = 5;
  localparam int C      = 5;
  localparam int MAXK   = 4;
  localparam int CH     = 2;
  localparam int K_BITS = $clog2(MAXK + 1);
  localparam int XAW    = $clog2(CH * R * C);
  localparam int WAW    = $clog2(CH * MAXK * MAXK);
  localparam int XN     = CH * R * C;
  localparam int WN     = CH * MAXK * MAXK;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  start = 1'b0;
  logic [K_BITS-1:0]     K = K_BITS'(1);
  logic                  stride2 = 1'b0;
  logic signed [INW-1:0] B = '0;
  logic [XAW-1:0]        X_read_addr;
  logic [WAW-1:0]        W_read_addr;
  logic signed [INW-1:0] X_data = '0;
  logic signed [INW-1:0] W_data = '0;
  logic                  done, busy;

  logic signed [INW-1:0] xmem [XN];
  logic signed [INW-1:0] wmem [WN];

  conv_core_v2_if #(.INW(INW), .MAXK(MAXK), .CH(CH)) out_if ();

  conv_core_v2 #(.INW(INW), .R(R), .C(C), .MAXK(MAXK), .CH(CH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .K           (K),
    .stride2     (stride2),
    .B           (B),
    .X_read_addr (X_read_addr),
    .X_data      (X_data),
    .W_read_addr (W_read_addr),
    .W_data      (W_data),
    .done        (done),
    .busy        (busy),
    .axis        (out_if)
  );

  always #5 clk = ~clk;

  // Single-cycle-latency read memories.
  always @(posedge clk) begin
    X_data <= (32'(X_read_addr) < XN) ? xmem[X_read_addr] : '0;
    W_data <= (32'(W_read_addr) < WN) ? wmem[W_read_addr] : '0;
  end

  int     cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint exp_q[$];
  int     n_cmp = 0, n_bad = 0;
  int     n_xfer = 0, done_cnt = 0, first_v_cyc = -1, done_cyc = -1;
  bit     ready_rnd = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint model(int k, int s, longint b, int r, int c);
    longint acc = b;
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < k; i++)
        for (int j = 0; j < k; j++)
          acc += longint'(xmem[ch * R * C + (r * s + i) * C + (c * s + j)])
               * longint'(wmem[ch * k * k + i * k + j]);
`ifdef CONV_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  initial begin
    out_if.OUT_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.OUT_TREADY = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
  initial begin
    bit     prev_stall = 1'b0;
    longint held = 0;
    longint got;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        got = longint'($signed(out_if.OUT_TDATA));
        if (out_if.OUT_TVALID && first_v_cyc < 0) first_v_cyc = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (out_if.OUT_TVALID) chk("busy_while_valid", longint'(busy), 1);
        if (prev_stall) begin
          chk("stall_valid_hold", longint'(out_if.OUT_TVALID), 1);
          chk("stall_data_hold", got, held);
        end
        if (out_if.OUT_TVALID && out_if.OUT_TREADY) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %0d, expected no output", got);
          end else begin
            chk("out_data", got, exp_q.pop_front());
          end
        end
        prev_stall = out_if.OUT_TVALID && !out_if.OUT_TREADY;
        held       = got;
      end
    end
  end

  task automatic run(input int k, input bit s2, input longint b, input bit rnd, input bit pulse);
    int s = s2 ? 2 : 1;
    int taps = CH * k * k;
    int nwin = 0;
    int start_cyc;
    for (int r = 0; r * s + k <= R; r++)
      for (int c = 0; c * s + k <= C; c++) begin
        exp_q.push_back(model(k, s, b, r, c));
        nwin++;
      end
    ready_rnd   = rnd;
    done_cnt    = 0;
    first_v_cyc = -1;
    done_cyc    = -1;
    n_xfer      = 0;
    @(posedge clk);
    #1;
    K         = K_BITS'(k);
    stride2   = s2;
    B         = INW'(b);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (pulse) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int t = 0; t < 4000 && done_cnt == 0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("outputs_left", exp_q.size(), 0);
    chk("outputs_seen", n_xfer, nwin);
    chk("busy_after_done", longint'(busy), 0);
    if (!rnd) begin
      chk("first_valid_latency", first_v_cyc - start_cyc, taps + 3);
      chk("done_latency", done_cyc - start_cyc, nwin * taps + 4);
    end
    exp_q.delete();
    ready_rnd = 1'b0;
  endtask

  task automatic reset_mid_run();
    for (int r = 0; r + 3 <= R; r++)
      for (int c = 0; c + 3 <= C; c++) exp_q.push_back(model(3, 1, 7, r, c));
    ready_rnd = 1'b0;
    done_cnt  = 0;
    n_xfer    = 0;
    @(posedge clk);
    #1;
    K       = K_BITS'(3);
    stride2 = 1'b0;
    B       = INW'(7);
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 0; t < 2000 && n_xfer < 3; t++) begin
      @(negedge clk);
      #1;
    end
    chk("third_output_reached", n_xfer, 3);
    reset_n = 1'b0;
    #1;
    chk("rst_async_tvalid", longint'(out_if.OUT_TVALID), 0);
    chk("rst_async_tdata", longint'($signed(out_if.OUT_TDATA)), 0);
    chk("rst_async_busy", longint'(busy), 0);
    chk("rst_async_done", longint'(done), 0);
    chk("rst_async_xaddr", longint'(X_read_addr), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_after_reset", longint'(busy), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [INW-1:0] rb;
    for (int a = 0; a < XN; a++) xmem[a] = '0;
    for (int a = 0; a < WN; a++) wmem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", longint'(out_if.OUT_TVALID), 0);
    chk("rst_tdata", longint'($signed(out_if.OUT_TDATA)), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_xaddr", longint'(X_read_addr), 0);
    chk("rst_waddr", longint'(W_read_addr), 0);
    reset_n = 1'b1;

    // Channel 0 ones, channel 1 zeros: behaves as a single channel, 9 + 2 = 11.
    for (int a = 0; a < XN; a++) xmem[a] = (a < R * C) ? INW'(1) : INW'(0);
    for (int a = 0; a < WN; a++) wmem[a] = INW'(1);
    run(3, 1'b0, 2, 1'b0, 1'b0);
    run(3, 1'b1, 2, 1'b0, 1'b0);
    for (int a = 0; a < XN; a++) xmem[a] = INW'(1);
    run(3, 1'b0, 2, 1'b0, 1'b0);

    for (int a = 0; a < XN; a++) xmem[a] = INW'(a);
    for (int a = 0; a < WN; a++) wmem[a] = -INW'(1);
    run(3, 1'b0, 0, 1'b1, 1'b1);

    for (int a = 0; a < XN; a++) xmem[a] = (a < R * C) ? INW'(1) : INW'(0);
    run(3, 1'b0, 0, 1'b0, 1'b0);

    for (int a = 0; a < XN; a++) xmem[a] = (a < R * C) ? INW'(3) : INW'(0);
    for (int a = 0; a < WN; a++) wmem[a] = INW'(3);
    run(1, 1'b0, -5, 1'b0, 1'b0);

    for (int a = 0; a < XN; a++) xmem[a] = INW'($urandom);
    for (int a = 0; a < WN; a++) wmem[a] = INW'($urandom);
    rb = INW'($urandom);
    run(4, 1'b1, longint'(rb), 1'b1, 1'b0);
    rb = INW'($urandom);
    run(2, 1'b1, longint'(rb), 1'b1, 1'b0);
    rb = INW'($urandom);
    run(2, 1'b0, longint'(rb), 1'b0, 1'b0);

    reset_mid_run();
    for (int a = 0; a < XN; a++) xmem[a] = INW'($urandom);
    rb = INW'($urandom);
    run(3, 1'b1, longint'(rb), 1'b1, 1'b0);
    run(3, 1'b0, longint'(rb), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
